// File: rtl/tmc_pio_in_irq.sv
// -----------------------------------------------------------------------------
// tmc_pio_in_irq
// Avalon-MM input PIO with synchroniser, optional per-bit debounce, per-bit
// edge capture (write-1-to-clear), interrupt mask and a registered level irq.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   address      word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect   slave select; readdata is forced to 0 while low
//   write_n      active-low write strobe
//   writedata    write data (lower WIDTH bits used)
//   in_port      asynchronous external inputs
//   readdata     registered read data, 1 clock latency
//   irq          registered level interrupt: |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module tmc_pio_in_irq #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned WARM   = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int unsigned WARM_W = $clog2(WARM + 1);
  localparam logic [WARM_W-1:0] WARM_VAL = WARM_W'(WARM);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_s;
  logic [WIDTH-1:0]  filtered_s;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  ec_q, ec_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic              warming_s;
  logic              wr_en_s;
  logic [WIDTH-1:0]  clr_s;
  logic [WIDTH-1:0]  rise_s, fall_s, evt_raw_s, evt_s;
  logic              unused_wd_s;

  // Upper writedata bits have no register behind them when WIDTH < 32.
  assign unused_wd_s = ^writedata;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign warming_s = (warm_q != WARM_VAL);
  assign readdata  = readdata_q;
  assign irq       = irq_q;

  // Metastability synchroniser chain, one flop row per stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  generate
    if (DEBOUNCE_CYCLES > 0) begin : g_deb
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q [WIDTH];
      logic [CNT_W-1:0] cnt_d [WIDTH];
      logic [WIDTH-1:0] filt_q, filt_d;

      // Per-bit debounce: the filtered bit follows only after DEBOUNCE_CYCLES
      // consecutive mismatching samples; during warm-up it tracks sync directly.
      always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          cnt_d[i]  = cnt_q[i];
          filt_d[i] = filt_q[i];
          if (warming_s) begin
            filt_d[i] = sync_s[i];
            cnt_d[i]  = '0;
          end else if (sync_s[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            filt_d[i] = sync_s[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      // Debounce counter and filtered-value registers.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filt_q <= '0;
          for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          filt_q <= filt_d;
          for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end

      assign filtered_s = filt_q;
    end else begin : g_bypass
      assign filtered_s = sync_s;
    end
  endgenerate

  // Edge detection; suppressed during warm-up so a level present at reset
  // release is not mistaken for an edge.
  always_comb begin
    rise_s = filtered_s & ~prev_q;
    fall_s = ~filtered_s & prev_q;
    case (EDGE_MODE)
      32'd0:   evt_raw_s = rise_s;
      32'd1:   evt_raw_s = fall_s;
      default: evt_raw_s = rise_s | fall_s;
    endcase
    if (warming_s) begin
      evt_s = '0;
    end else begin
      evt_s = evt_raw_s;
    end
  end

  // Register-file next state: W1C edge capture (set wins), mask, warm-up count.
  always_comb begin
    wr_en_s = chipselect & ~write_n;
    if (wr_en_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_en_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    ec_d   = (ec_q & ~clr_s) | evt_s;
    prev_d = filtered_s;
    irq_d  = |(ec_q & mask_q);
    if (warming_s) begin
      warm_d = warm_q + WARM_W'(1);
    end else begin
      warm_d = warm_q;
    end
  end

  // Read mux, registered every clock; deselected reads return zero.
  always_comb begin
    readdata_d = 32'd0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata_d[WIDTH-1:0] = filtered_s;
        2'd2:    readdata_d[WIDTH-1:0] = mask_q;
        2'd3:    readdata_d[WIDTH-1:0] = ec_q;
        default: readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      ec_q       <= '0;
      mask_q     <= '0;
      warm_q     <= '0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      ec_q       <= ec_d;
      mask_q     <= mask_d;
      warm_q     <= warm_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_tmc_pio_in_irq.sv
// -----------------------------------------------------------------------------
// tb_tmc_pio_in_irq
// Two instances share all inputs:
//   u0: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0 (rising)
//   u1: SYNC_STAGES=3, DEBOUNCE_CYCLES=0, EDGE_MODE=2 (any)
// A history-based reference model predicts readdata/irq of both every clock.
// -----------------------------------------------------------------------------
module tb_tmc_pio_in_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int checks;
  int failures;

  tmc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  tmc_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  in_h  [2][8];   // in_port samples, newest first
  logic [7:0]  sh    [2][8];   // post-warm-up sync samples, newest first
  int          sh_n  [2];
  logic [7:0]  m_filt[2];
  logic [7:0]  m_prev[2];
  logic [7:0]  m_ec  [2];
  logic [7:0]  m_mask[2];
  int          m_w   [2];
  logic [31:0] m_rd  [2];
  logic        m_irq [2];

  function automatic int s_of(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int d_of(input int i); return (i == 0) ? 4 : 0; endfunction
  function automatic int e_of(input int i); return (i == 0) ? 0 : 2; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        in_h[i][k] = 8'h00;
        sh[i][k]   = 8'h00;
      end
      sh_n[i]   = 0;
      m_filt[i] = 8'h00;
      m_prev[i] = 8'h00;
      m_ec[i]   = 8'h00;
      m_mask[i] = 8'h00;
      m_w[i]    = 0;
      m_rd[i]   = 32'h0;
      m_irq[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [7:0] sp, fv, evt, nf, clr, nec, nmask;
    logic [31:0] nrd;
    logic run, warming, wr;
    int s, d, warm;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      s    = s_of(i);
      d    = d_of(i);
      warm = s + d + 1;
      sp   = in_h[i][s-1];
      fv   = (d == 0) ? sp : m_filt[i];
      warming = (m_w[i] < warm);
      case (e_of(i))
        0:       evt = fv & ~m_prev[i];
        1:       evt = ~fv & m_prev[i];
        default: evt = fv ^ m_prev[i];
      endcase
      if (warming) evt = 8'h00;
      nf = m_filt[i];
      if (d > 0) begin
        if (warming) begin
          nf = sp;
          sh_n[i] = 0;
        end else begin
          for (int k = 7; k > 0; k--) sh[i][k] = sh[i][k-1];
          sh[i][0] = sp;
          if (sh_n[i] < 8) sh_n[i]++;
          // a bit flips once its last d samples all disagree with it
          for (int b = 0; b < 8; b++) begin
            run = (sh_n[i] >= d);
            for (int k = 0; k < d; k++) begin
              if (sh[i][k][b] == m_filt[i][b]) run = 1'b0;
            end
            if (run) nf[b] = sp[b];
          end
        end
      end
      wr    = chipselect && !write_n;
      clr   = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      nec   = (m_ec[i] & ~clr) | evt;
      nmask = (wr && address == 2'd2) ? writedata[7:0] : m_mask[i];
      nrd   = 32'h0;
      if (chipselect) begin
        if (address == 2'd0) nrd = {24'h0, fv};
        if (address == 2'd2) nrd = {24'h0, m_mask[i]};
        if (address == 2'd3) nrd = {24'h0, m_ec[i]};
      end
      m_irq[i]  = |(m_ec[i] & m_mask[i]);
      m_rd[i]   = nrd;
      m_ec[i]   = nec;
      m_mask[i] = nmask;
      m_prev[i] = fv;
      m_filt[i] = nf;
      if (warming) m_w[i]++;
      for (int k = 7; k > 0; k--) in_h[i][k] = in_h[i][k-1];
      in_h[i][0] = in_port;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("u0_readdata", rd0, m_rd[0]);
    chk("u0_irq", {31'h0, irq0}, {31'h0, m_irq[0]});
    chk("u1_readdata", rd1, m_rd[1]);
    chk("u1_irq", {31'h0, irq1}, {31'h0, m_irq[1]});
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    bus_idle();
  endtask

  task automatic bus_rd(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    in_port  = 8'hFF;
    bus_idle();
    model_reset();

    repeat (3) step();
    chk("reset_rd0", rd0, 32'h0);
    chk("reset_irq1", {31'h0, irq1}, 32'h0);

    // high inputs at reset release must not create edges
    reset_n = 1'b1;
    repeat (20) step();
    bus_rd(2'd0);
    chk("warm_data_u0", rd0, 32'hFF);
    chk("warm_data_u1", rd1, 32'hFF);
    bus_rd(2'd3);
    chk("warm_ec_u0", rd0, 32'h0);
    chk("warm_ec_u1", rd1, 32'h0);
    chk("warm_irq0", {31'h0, irq0}, 32'h0);

    // rising capture on bit 0 with mask 0x01
    bus_wr(2'd2, 32'h01);
    in_port = 8'hFE;
    repeat (15) step();
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hFF;
    repeat (15) step();
    bus_rd(2'd3);
    chk("rise_ec_u0", rd0, 32'h01);
    chk("rise_irq0", {31'h0, irq0}, 32'h1);
    bus_wr(2'd3, 32'h01);
    chk("w1c_irq0_lag", {31'h0, irq0}, 32'h1);
    step();
    chk("w1c_irq0_low", {31'h0, irq0}, 32'h0);

    // debounce: 3-clock glitch rejected, sustained change accepted
    in_port = 8'hFB;
    repeat (15) step();
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hFF;
    repeat (3) step();
    in_port = 8'hFB;
    repeat (15) step();
    bus_rd(2'd0);
    chk("glitch_data_u0", rd0, 32'hFB);
    bus_rd(2'd3);
    chk("glitch_ec_u0", rd0, 32'h00);
    chk("glitch_ec_u1", rd1, 32'h04);
    in_port = 8'hFF;
    repeat (15) step();
    bus_rd(2'd0);
    chk("stable_data_u0", rd0, 32'hFF);
    bus_rd(2'd3);
    chk("stable_ec_u0", rd0, 32'h04);

    // W1C coinciding with a new edge on u1 bit 3: set wins
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hF7;
    repeat (3) step();
    bus_wr(2'd3, 32'h08);
    bus_rd(2'd3);
    chk("collide_ec_u1", rd1, 32'h08);

    // any-edge capture with mask off, then enable mask
    bus_wr(2'd2, 32'h00);
    bus_wr(2'd3, 32'hFF);
    in_port = 8'hD7;
    repeat (10) step();
    bus_rd(2'd3);
    chk("fall_ec_u1", rd1, 32'h20);
    chk("masked_irq1", {31'h0, irq1}, 32'h0);
    bus_wr(2'd2, 32'h20);
    bus_rd(2'd3);
    chk("unmasked_irq1", {31'h0, irq1}, 32'h1);
    chk("unmasked_rd1", rd1, 32'h20);

    // asynchronous reset while irq is high
    reset_n = 1'b0;
    #1;
    chk("async_rst_rd1", rd1, 32'h0);
    chk("async_rst_irq1", {31'h0, irq1}, 32'h0);
    model_reset();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (12) step();
    bus_rd(2'd2);
    chk("post_rst_mask_u1", rd1, 32'h0);
    bus_rd(2'd3);
    chk("post_rst_ec_u0", rd0, 32'h0);
    chk("post_rst_ec_u1", rd1, 32'h0);
    bus_rd(2'd0);
    chk("post_rst_data_u1", rd1, 32'hD7);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) in_port = in_port ^ (8'h01 << $urandom_range(7));
      chipselect = ($urandom_range(3) != 0);
      address    = 2'($urandom_range(3));
      write_n    = ($urandom_range(5) != 0);
      writedata  = $urandom;
      if (n == 300) begin
        reset_n = 1'b0;
        #1;
        chk("rand_rst_rd0", rd0, 32'h0);
        chk("rand_rst_irq0", {31'h0, irq0}, 32'h0);
        model_reset();
      end
      if (n == 303) reset_n = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
